dmem_access_unit: RTL and testbench

Load/store initiator that sits between the CPU execute stage and the `dmem` data memory. It accepts one byte, halfword or word request at a time over a valid/ready handshake, and drives `dmem`'s `readAddress`/`writeAddress`/`writeData`/`MemRead`/`MemWrite` pins with clean one-cycle strobes. It returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write, and misaligned or out-of-range requests are reported as errors.

---
 rtl/dmem_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Load/store initiator for the dmem data memory: one byte/half/word request at a time,
// sub-word stores done as read-modify-write, every memory-side pin driven straight from a flop.
module dmem_access_unit #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] readAddress,
    output logic [ADDR_W-1:0] writeAddress,
    output logic [31:0]       writeData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       readData
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} stateT;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    stateT             state, stateNext;
    logic              curWrite, writeNext;
    logic [1:0]        curSize, sizeNext;
    logic              curUnsigned, unsNext;
    logic [ADDR_W+1:0] curAddr, addrNext;
    logic [15:0]       curWdata, wdataNext;
    logic              memReadNext, memWriteNext;
    logic [ADDR_W-1:0] readAddressNext, writeAddressNext;
    logic [31:0]       writeDataNext;
    logic              respValidNext, respErrNext;
    logic [31:0]       respRdataNext;
    logic              reqErr;

    function automatic logic [31:0] extendLane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic isUnsigned);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = {{24{~isUnsigned & b[7]}}, b};
            SZ_HALF: r = {{16{~isUnsigned & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mergeLane(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic [15:0] wdata);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) r[{lane, 3'b000} +: 8] = wdata[7:0];
        else                 r[{lane[1], 4'b0000} +: 16] = wdata;
        return r;
    endfunction

    assign reqErr = (req_size == 2'b11)
                 || (req_size == SZ_HALF && req_addr[0])
                 || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
                 || (req_addr[31:ADDR_W+2] != '0);

    // State is held at IDLE during reset, so reset must be masked here explicitly.
    assign req_ready = (state == IDLE) && !reset;

    always_comb begin
        stateNext        = state;
        writeNext        = curWrite;
        sizeNext         = curSize;
        unsNext          = curUnsigned;
        addrNext         = curAddr;
        wdataNext        = curWdata;
        memReadNext      = 1'b0;
        memWriteNext     = 1'b0;
        readAddressNext  = readAddress;
        writeAddressNext = writeAddress;
        writeDataNext    = writeData;
        respValidNext    = resp_valid;
        respErrNext      = resp_err;
        respRdataNext    = resp_rdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    writeNext = req_write;
                    sizeNext  = req_size;
                    unsNext   = req_unsigned;
                    addrNext  = req_addr[ADDR_W+1:0];
                    wdataNext = req_wdata[15:0];
                    if (reqErr) begin
                        stateNext     = RESP;
                        respValidNext = 1'b1;
                        respErrNext   = 1'b1;
                        respRdataNext = '0;
                    end else if (req_write && req_size == SZ_WORD) begin
                        stateNext        = WRITE;
                        memWriteNext     = 1'b1;
                        writeAddressNext = req_addr[ADDR_W+1:2];
                        writeDataNext    = req_wdata;
                    end else begin
                        stateNext       = READ;
                        memReadNext     = 1'b1;
                        readAddressNext = req_addr[ADDR_W+1:2];
                    end
                end
            end
            READ: begin
                if (curWrite) begin
                    stateNext        = WRITE;
                    memWriteNext     = 1'b1;
                    writeAddressNext = curAddr[ADDR_W+1:2];
                    writeDataNext    = mergeLane(readData, curSize, curAddr[1:0], curWdata);
                end else begin
                    stateNext     = RESP;
                    respValidNext = 1'b1;
                    respErrNext   = 1'b0;
                    respRdataNext = extendLane(readData, curSize, curAddr[1:0], curUnsigned);
                end
            end
            WRITE: begin
                stateNext     = RESP;
                respValidNext = 1'b1;
                respErrNext   = 1'b0;
                respRdataNext = '0;
            end
            RESP: begin
                if (resp_ready) begin
                    stateNext     = IDLE;
                    respValidNext = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            curWrite     <= 1'b0;
            curSize      <= '0;
            curUnsigned  <= 1'b0;
            curAddr      <= '0;
            curWdata     <= '0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            readAddress  <= '0;
            writeAddress <= '0;
            writeData    <= '0;
            resp_valid   <= 1'b0;
            resp_err     <= 1'b0;
            resp_rdata   <= '0;
        end else begin
            state        <= stateNext;
            curWrite     <= writeNext;
            curSize      <= sizeNext;
            curUnsigned  <= unsNext;
            curAddr      <= addrNext;
            curWdata     <= wdataNext;
            MemRead      <= memReadNext;
            MemWrite     <= memWriteNext;
            readAddress  <= readAddressNext;
            writeAddress <= writeAddressNext;
            writeData    <= writeDataNext;
            resp_valid   <= respValidNext;
            resp_err     <= respErrNext;
            resp_rdata   <= respRdataNext;
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a behavioural dmem plus a byte-level reference memory,
// directed scenarios followed by randomized requests.
module tb_dmem_access_unit;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DEPTH  = 512;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              resp_valid, resp_ready, resp_err;
    logic [31:0]       resp_rdata;
    logic [ADDR_W-1:0] readAddress, writeAddress;
    logic [31:0]       writeData, readData;
    logic              MemRead, MemWrite;

    logic [31:0]       mem    [0:DEPTH-1];
    logic [31:0]       refMem [0:DEPTH-1];
    logic              loadEn;
    logic [ADDR_W-1:0] loadIdx;
    logic [31:0]       loadVal;

    int nTests = 0;
    int nFail  = 0;
    int rdCnt, wrCnt, overlapCnt;
    logic [ADDR_W-1:0] lastRdAddr, lastWrAddr;

    dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .readAddress(readAddress), .writeAddress(writeAddress), .writeData(writeData),
        .MemRead(MemRead), .MemWrite(MemWrite), .readData(readData)
    );

    always #5 clk = ~clk;

    assign readData = mem[readAddress];

    always @(posedge clk) begin
        if (loadEn)        mem[loadIdx] <= loadVal;
        else if (MemWrite) mem[writeAddress] <= writeData;
    end

    always @(negedge clk) begin
        if (MemRead)  begin rdCnt++; lastRdAddr = readAddress; end
        if (MemWrite) begin wrCnt++; lastWrAddr = writeAddress; end
        if (MemRead && MemWrite) overlapCnt++;
    end

    function automatic int unsigned sizeBits(input logic [1:0] sz);
        return (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] word, val, mask;
        int unsigned sh, nb;
        word = refMem[a[10:2]];
        nb   = sizeBits(sz);
        if (nb == 32) return word;
        sh   = (a % 4) * 8;
        mask = (32'd1 << nb) - 1;
        val  = (word >> sh) & mask;
        if (!uns && val[nb-1]) val = val | ~mask;
        return val;
    endfunction

    task automatic refStore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int unsigned sh, nb;
        nb   = sizeBits(sz);
        sh   = (a % 4) * 8;
        mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 1);
        refMem[a[10:2]] = (refMem[a[10:2]] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    // Drives one request, waits (bounded) for the response; lat counts edges from accept to resp_valid.
    task automatic issue(input logic w, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] wd, input bit consume,
                         output logic [31:0] rdata, output logic err, output int lat);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        rdCnt = 0; wrCnt = 0;
        guard = 0;
        while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!req_ready) begin
            nTests++; nFail++;
            $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        rdata = resp_rdata;
        err   = resp_err;
        if (consume) begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        loadEn = 1'b0; loadIdx = '0; loadVal = '0;
        overlapCnt = 0; rdCnt = 0; wrCnt = 0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            loadEn = 1'b1; loadIdx = ADDR_W'(i); loadVal = $urandom; refMem[i] = loadVal;
        end
        @(negedge clk); loadEn = 1'b0;
        nTests++;
        if (req_ready !== 1'b0) begin
            nFail++; $display("FAIL reset_req_ready_low: got %0b required 0", req_ready);
        end
        nTests++;
        if ({resp_valid, resp_err, MemRead, MemWrite, resp_rdata, readAddress, writeAddress, writeData} !== '0) begin
            nFail++;
            $display("FAIL reset_outputs: valid=%0b err=%0b rd=%0b wr=%0b rdata=%h ra=%0d wa=%0d wd=%h required all 0",
                     resp_valid, resp_err, MemRead, MemWrite, resp_rdata, readAddress, writeAddress, writeData);
        end
        reset = 1'b0; #1;
        nTests++;
        if (req_ready !== 1'b1) begin
            nFail++; $display("FAIL reset_release_ready: got %0b required 1", req_ready);
        end
    endtask

    task automatic test_directed;
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEAD_BEEF, 1'b1, rd, er, lat);
        refStore(32'h010, 2'd2, 32'hDEAD_BEEF);
        nTests++;
        if (lat != 2 || er !== 1'b0 || wrCnt != 1 || rdCnt != 0 || lastWrAddr !== 9'd4) begin
            nFail++; $display("FAIL word_store: lat=%0d err=%0b wr=%0d rd=%0d wa=%0d required 2/0/1/0/4",
                              lat, er, wrCnt, rdCnt, lastWrAddr);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'hDEAD_BEEF || lat != 2 || rdCnt != 1 || wrCnt != 0 || lastRdAddr !== 9'd4) begin
            nFail++; $display("FAIL word_load: rdata=%h lat=%0d rd=%0d wr=%0d ra=%0d required deadbeef/2/1/0/4",
                              rd, lat, rdCnt, wrCnt, lastRdAddr);
        end
        issue(1'b1, 2'd0, 1'b0, 32'h012, 32'h0000_0055, 1'b1, rd, er, lat);
        refStore(32'h012, 2'd0, 32'h55);
        nTests++;
        if (lat != 3 || er !== 1'b0 || rdCnt != 1 || wrCnt != 1) begin
            nFail++; $display("FAIL byte_store: lat=%0d err=%0b rd=%0d wr=%0d required 3/0/1/1", lat, er, rdCnt, wrCnt);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'hDE55_BEEF) begin
            nFail++; $display("FAIL merged_word: got %h required de55beef", rd);
        end
        issue(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'hFFFF_FFDE) begin
            nFail++; $display("FAIL signed_byte: got %h required ffffffde", rd);
        end
        issue(1'b0, 2'd1, 1'b1, 32'h010, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'h0000_BEEF) begin
            nFail++; $display("FAIL unsigned_half: got %h required 0000beef", rd);
        end
        issue(1'b0, 2'd1, 1'b0, 32'h012, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'hFFFF_DE55) begin
            nFail++; $display("FAIL signed_half: got %h required ffffde55", rd);
        end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat; int diffs;
        logic [31:0] eAddr [3];
        logic [1:0]  eSize [3];
        logic        eWr   [3];
        eAddr[0] = 32'h011; eSize[0] = 2'd1; eWr[0] = 1'b0;
        eAddr[1] = 32'h800; eSize[1] = 2'd2; eWr[1] = 1'b1;
        eAddr[2] = 32'h010; eSize[2] = 2'd3; eWr[2] = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            issue(eWr[k], eSize[k], 1'b0, eAddr[k], 32'h1234_5678, 1'b1, rd, er, lat);
            nTests++;
            if (er !== 1'b1 || lat != 1 || rd !== 32'h0 || rdCnt != 0 || wrCnt != 0) begin
                nFail++; $display("FAIL error_case%0d: err=%0b lat=%0d rdata=%h rd=%0d wr=%0d required 1/1/0/0/0",
                                  k, er, lat, rd, rdCnt, wrCnt);
            end
        end
        diffs = 0;
        for (int unsigned i = 0; i < DEPTH; i++) if (mem[i] !== refMem[i]) diffs++;
        nTests++;
        if (diffs != 0) begin
            nFail++; $display("FAIL error_mem_unchanged: %0d words differ required 0", diffs);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd; logic er; int lat; int bad;
        logic [31:0] exp;
        exp = refLoad(32'h010, 2'd2, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 1'b0, rd, er, lat);
        bad = 0;
        for (int unsigned c = 0; c < 5; c++) begin
            if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        nTests++;
        if (bad != 0 || rd !== exp) begin
            nFail++; $display("FAIL backpressure_hold: %0d unstable cycles, rdata=%h required %h", bad, rd, exp);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        nTests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            nFail++; $display("FAIL backpressure_release: valid=%0b ready=%0b required 0/1", resp_valid, req_ready);
        end
        issue(1'b0, 2'd0, 1'b1, 32'h011, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== refLoad(32'h011, 2'd0, 1'b1) || lat != 2) begin
            nFail++; $display("FAIL backpressure_next_req: rdata=%h lat=%0d required %h/2",
                              rd, lat, refLoad(32'h011, 2'd0, 1'b1));
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 2'd2, 1'b0, 32'h7FC, 32'hA5A5_1234, 1'b1, rd, er, lat);
        refStore(32'h7FC, 2'd2, 32'hA5A5_1234);
        nTests++;
        if (er !== 1'b0 || lastWrAddr !== 9'd511) begin
            nFail++; $display("FAIL top_word_legal: err=%0b wa=%0d required 0/511", er, lastWrAddr);
        end
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h7FC; req_wdata = 32'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rdCnt = 0; wrCnt = 0;
        nTests++;
        if (MemRead !== 1'b1) begin
            nFail++; $display("FAIL reset_mid_in_read: MemRead=%0b required 1", MemRead);
        end
        #1 reset = 1'b1;
        #1;
        nTests++;
        if ({resp_valid, resp_err, MemRead, MemWrite, req_ready, resp_rdata, readAddress, writeAddress, writeData} !== '0) begin
            nFail++;
            $display("FAIL reset_mid_outputs: valid=%0b rd=%0b wr=%0b ready=%0b ra=%0d wa=%0d wd=%h required all 0",
                     resp_valid, MemRead, MemWrite, req_ready, readAddress, writeAddress, writeData);
        end
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nTests++;
        if (wrCnt != 0 || mem[511] !== 32'hA5A5_1234) begin
            nFail++; $display("FAIL reset_mid_no_write: writes=%0d mem511=%h required 0/a5a51234", wrCnt, mem[511]);
        end
        issue(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0, 1'b1, rd, er, lat);
        nTests++;
        if (rd !== 32'hA5A5_1234 || er !== 1'b0) begin
            nFail++; $display("FAIL reset_mid_reload: rdata=%h err=%0b required a5a51234/0", rd, er);
        end
    endtask

    task automatic test_random;
        logic [31:0] rd, a, wd, expRd; logic er, w, uns, expErr; logic [1:0] sz;
        int lat, expLat, expRdN, expWrN;
        int unsigned kind, idx, lane;
        for (int unsigned n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            sz   = (kind == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            w    = 1'($urandom_range(0, 1));
            uns  = 1'($urandom_range(0, 1));
            wd   = $urandom;
            idx  = (kind < 5) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            lane = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) lane = (sz == 2'd2) ? 0 : (sz == 2'd1) ? (lane & 2) : lane;
            a = idx * 4 + lane;
            if (kind == 1) a = a | (32'd1 << $urandom_range(11, 31));
            expErr = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 32'h800);
            expLat = expErr ? 1 : (!w || sz == 2'd2) ? 2 : 3;
            expRdN = (expErr || (w && sz == 2'd2)) ? 0 : 1;
            expWrN = (!expErr && w) ? 1 : 0;
            expRd  = (expErr || w) ? 32'h0 : refLoad(a, sz, uns);
            issue(w, sz, uns, a, wd, 1'b1, rd, er, lat);
            if (!expErr && w) refStore(a, sz, wd);
            nTests++;
            if (rd !== expRd || er !== expErr || lat != expLat) begin
                nFail++; $display("FAIL rand%0d_resp: w=%0b sz=%0d a=%h rdata=%h err=%0b lat=%0d required %h/%0b/%0d",
                                  n, w, sz, a, rd, er, lat, expRd, expErr, expLat);
            end
            nTests++;
            if (rdCnt != expRdN || wrCnt != expWrN) begin
                nFail++; $display("FAIL rand%0d_strobes: reads=%0d writes=%0d required %0d/%0d",
                                  n, rdCnt, wrCnt, expRdN, expWrN);
            end
            if (!expErr) begin
                nTests++;
                if (mem[a[10:2]] !== refMem[a[10:2]] || (expRdN == 1 && lastRdAddr !== a[10:2])) begin
                    nFail++; $display("FAIL rand%0d_mem: word=%h ra=%0d required %h/%0d",
                                      n, mem[a[10:2]], lastRdAddr, refMem[a[10:2]], a[10:2]);
                end
            end
        end
        nTests++;
        if (overlapCnt != 0) begin
            nFail++; $display("FAIL strobe_overlap: %0d cycles with both strobes required 0", overlapCnt);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_errors;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
